ml_acc_seq: RTL and testbench

Sequencer that runs one dense-layer dot-product job on the team's four-lane, four-neuron int8 MAC datapath (`parallel_ACC`-style: one activation word, four weight words, four running sums in, four sums out, combinational). It fetches activation and weight words from two valid/ready streams and drives the datapath's lane-valid mask, operands and running sums. It accumulates over a programmable element count and returns four 32-bit neuron results on a result handshake, with optional ReLU. It sits between the AHB register front-end or DMA and the MAC datapath, replacing per-word CPU writes.

---
 rtl/ml_acc_pkg.sv | 26 ++
 rtl/ml_acc_accum_bank.sv | 39 +++
 rtl/ml_acc_seq.sv | 150 +++++++++++++++
 tb/tb_ml_acc_seq.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_acc_pkg.sv
// Shared types and helpers for the ml_acc_seq dot-product sequencer.
// Lane/neuron counts match the four-lane, four-neuron int8 MAC datapath.
package ml_acc_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned NEURONS = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Tail element count (len mod 4) to lane-valid mask; 0 means a full word.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] tail);
    logic [LANES-1:0] mask;
    unique case (tail)
      2'd1:    mask = 4'b0001;
      2'd2:    mask = 4'b0011;
      2'd3:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ml_acc_accum_bank.sv
// Four 32-bit neuron accumulators: bias load on start, update from the datapath on fire,
// synchronous clear, and the ReLU result mux.
module ml_acc_accum_bank
  import ml_acc_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_clr,
  input  logic                      i_load,
  input  logic                      i_relu,
  input  logic                      i_fire,
  input  logic [NEURONS-1:0][31:0]  i_bias,
  input  logic [NEURONS-1:0][31:0]  i_dp_out,
  output logic [NEURONS-1:0][31:0]  o_acc,
  output logic [NEURONS-1:0][31:0]  o_res
);

  logic [NEURONS-1:0][31:0] r_acc;
  logic                     r_relu;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_acc  <= '0;
      r_relu <= 1'b0;
    end else if (i_load) begin
      r_acc  <= i_bias;
      r_relu <= i_relu;
    end else if (i_fire) begin
      r_acc  <= i_dp_out;
    end
  end

  always_comb begin
    o_acc = r_acc;
    for (int n = 0; n < NEURONS; n++) begin
      o_res[n] = (r_relu && r_acc[n][31]) ? 32'd0 : r_acc[n];
    end
  end

endmodule

// File: rtl/ml_acc_seq.sv
// Dense-layer job sequencer: streams activation/weight words into the external int8 MAC
// datapath, accumulates over len elements and hands four neuron results back.
module ml_acc_seq
  import ml_acc_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               relu,
  input  logic [31:0]        bias0,
  input  logic [31:0]        bias1,
  input  logic [31:0]        bias2,
  input  logic [31:0]        bias3,
  output logic               busy,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [31:0]        act_data,
  input  logic               wgt_valid,
  output logic               wgt_ready,
  input  logic [127:0]       wgt_data,
  output logic [LANES-1:0]   dp_valid,
  output logic [31:0]        dp_a,
  output logic [31:0]        dp_w0,
  output logic [31:0]        dp_w1,
  output logic [31:0]        dp_w2,
  output logic [31:0]        dp_w3,
  output logic [31:0]        dp_sum0,
  output logic [31:0]        dp_sum1,
  output logic [31:0]        dp_sum2,
  output logic [31:0]        dp_sum3,
  input  logic [31:0]        dp_out0,
  input  logic [31:0]        dp_out1,
  input  logic [31:0]        dp_out2,
  input  logic [31:0]        dp_out3,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res0,
  output logic [31:0]        res1,
  output logic [31:0]        res2,
  output logic [31:0]        res3
);

  // ceil(len/4) always fits in LEN_W-1 bits.
  localparam int unsigned WW = LEN_W - 1;

  state_e                   r_state;
  state_e                   w_state_next;
  logic [WW-1:0]            r_words;
  logic [1:0]               r_tail;
  logic [WW-1:0]            w_words_init;
  logic                     w_start_ok;
  logic                     w_fire;
  logic                     w_last;
  logic [NEURONS-1:0][31:0] w_bias;
  logic [NEURONS-1:0][31:0] w_dp_out;
  logic [NEURONS-1:0][31:0] w_acc;
  logic [NEURONS-1:0][31:0] w_res;

  assign w_words_init = WW'((32'(len) + 32'd3) >> 2);
  assign w_start_ok   = (r_state == StIdle) && start;
  assign w_fire       = (r_state == StRun) && act_valid && wgt_valid;
  assign w_last       = (r_words == WW'(1));
  assign w_bias       = {bias3, bias2, bias1, bias0};
  assign w_dp_out     = {dp_out3, dp_out2, dp_out1, dp_out0};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_words <= '0;
      r_tail  <= '0;
    end else if (w_start_ok) begin
      r_words <= w_words_init;
      r_tail  <= len[1:0];
    end else if (w_fire) begin
      r_words <= r_words - WW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (start) w_state_next = (w_words_init == '0) ? StDone : StRun;
      StRun:  if (w_fire && w_last) w_state_next = StDone;
      StDone: if (res_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy      = (r_state != StIdle);
    act_ready = 1'b0;
    wgt_ready = 1'b0;
    res_valid = 1'b0;
    dp_valid  = '0;
    dp_a      = '0;
    dp_w0     = '0;
    dp_w1     = '0;
    dp_w2     = '0;
    dp_w3     = '0;
    unique case (r_state)
      StRun: begin
        // Cross-coupled readies: a word is consumed only when both streams present one.
        act_ready = wgt_valid;
        wgt_ready = act_valid;
        if (w_fire) begin
          dp_valid = (w_last && (r_tail != 2'd0)) ? lane_mask(r_tail) : 4'b1111;
          dp_a     = act_data;
          dp_w0    = wgt_data[31:0];
          dp_w1    = wgt_data[63:32];
          dp_w2    = wgt_data[95:64];
          dp_w3    = wgt_data[127:96];
        end
      end
      StDone:  res_valid = 1'b1;
      default: ;
    endcase
  end

  ml_acc_accum_bank u_accum_bank (
    .i_clk    (HCLK),
    .i_clr    (HRESET),
    .i_load   (w_start_ok),
    .i_relu   (relu),
    .i_fire   (w_fire),
    .i_bias   (w_bias),
    .i_dp_out (w_dp_out),
    .o_acc    (w_acc),
    .o_res    (w_res)
  );

  assign dp_sum0 = w_acc[0];
  assign dp_sum1 = w_acc[1];
  assign dp_sum2 = w_acc[2];
  assign dp_sum3 = w_acc[3];
  assign res0    = w_res[0];
  assign res1    = w_res[1];
  assign res2    = w_res[2];
  assign res3    = w_res[3];

endmodule

// File: tb/tb_ml_acc_seq.sv
// Bench for ml_acc_seq: models the MAC datapath, drives randomized streams and compares
// results against an element-wise dot-product reference.
module tb_ml_acc_seq;

  logic         HCLK = 1'b0;
  logic         HRESET = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  len_in = '0;
  logic         relu_in = 1'b0;
  logic [31:0]  bias_in [4] = '{default: '0};
  logic         busy;
  logic         act_valid = 1'b0;
  logic         act_ready;
  logic [31:0]  act_data = '0;
  logic         wgt_valid = 1'b0;
  logic         wgt_ready;
  logic [127:0] wgt_data = '0;
  logic [3:0]   dp_valid;
  logic [31:0]  dp_a;
  logic [31:0]  dp_w [4];
  logic [31:0]  dp_sum [4];
  logic [31:0]  dp_out [4];
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [31:0]  res_o [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  ml_acc_seq #(.LEN_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .len(len_in), .relu(relu_in),
    .bias0(bias_in[0]), .bias1(bias_in[1]), .bias2(bias_in[2]), .bias3(bias_in[3]),
    .busy(busy),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .dp_valid(dp_valid), .dp_a(dp_a),
    .dp_w0(dp_w[0]), .dp_w1(dp_w[1]), .dp_w2(dp_w[2]), .dp_w3(dp_w[3]),
    .dp_sum0(dp_sum[0]), .dp_sum1(dp_sum[1]), .dp_sum2(dp_sum[2]), .dp_sum3(dp_sum[3]),
    .dp_out0(dp_out[0]), .dp_out1(dp_out[1]), .dp_out2(dp_out[2]), .dp_out3(dp_out[3]),
    .res_valid(res_valid), .res_ready(res_ready),
    .res0(res_o[0]), .res1(res_o[1]), .res2(res_o[2]), .res3(res_o[3])
  );

  // External MAC datapath model: sum + masked lane-wise int8 products, mod 2^32.
  function automatic logic [31:0] mac(input logic [31:0] s, input logic [31:0] a,
                                      input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r = r + ({{24{a[8*i+7]}}, a[8*i +: 8]} * {{24{w[8*i+7]}}, w[8*i +: 8]});
    end
    return r;
  endfunction

  assign dp_out[0] = mac(dp_sum[0], dp_a, dp_w[0], dp_valid);
  assign dp_out[1] = mac(dp_sum[1], dp_a, dp_w[1], dp_valid);
  assign dp_out[2] = mac(dp_sum[2], dp_a, dp_w[2], dp_valid);
  assign dp_out[3] = mac(dp_sum[3], dp_a, dp_w[3], dp_valid);

  // Job description and observations gathered by run_job.
  logic [31:0]  g_act [$];
  logic [127:0] g_wgt [$];
  int unsigned  g_len;
  logic [31:0]  g_bias [4];
  logic         g_relu;
  int           g_drop;
  int           g_hold;
  bit           g_start_in_done;

  logic [31:0]  o_res [4];
  int           o_res_cycle;
  int           o_fires;
  logic [3:0]   o_masks [$];
  int           o_bad_hs;
  int           o_unstable;
  logic         o_idle_after;

  function automatic logic [31:0] model_res(input int n);
    int s;
    logic [31:0]  aw;
    logic [127:0] ww;
    logic signed [7:0] ab;
    logic signed [7:0] wb;
    s = int'(g_bias[n]);
    for (int k = 0; k < int'(g_len); k++) begin
      aw = g_act[k / 4];
      ww = g_wgt[k / 4];
      ab = aw[8 * (k % 4) +: 8];
      wb = ww[32 * n + 8 * (k % 4) +: 8];
      s = s + int'(ab) * int'(wb);
    end
    if (g_relu && s < 0) s = 0;
    return 32'(s);
  endfunction

  function automatic void make_job(input int unsigned len);
    g_len = len;
    g_act.delete();
    g_wgt.delete();
    for (int i = 0; i < int'((len + 3) / 4); i++) begin
      g_act.push_back($urandom);
      g_wgt.push_back({$urandom, $urandom, $urandom, $urandom});
    end
  endfunction

  // Drives one job end to end; starts and returns 1 time unit after a rising edge.
  task automatic run_job();
    int idx;
    int cyc;
    bit fire;
    logic [31:0] snap [4];
    o_masks.delete();
    o_bad_hs = 0;
    o_unstable = 0;
    o_fires = 0;
    o_res_cycle = -1;
    o_res = '{default: 'x};
    o_idle_after = 1'b0;
    len_in = 16'(g_len);
    relu_in = g_relu;
    bias_in = g_bias;
    start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    len_in = 16'($urandom);
    relu_in = 1'($urandom);
    for (int n = 0; n < 4; n++) bias_in[n] = $urandom;
    idx = 0;
    cyc = 1;
    while (cyc < 400) begin
      if (idx < g_act.size()) begin
        act_valid = ($urandom_range(99) >= 32'(g_drop));
        wgt_valid = ($urandom_range(99) >= 32'(g_drop));
        act_data = act_valid ? g_act[idx] : $urandom;
        wgt_data = wgt_valid ? g_wgt[idx] : {$urandom, $urandom, $urandom, $urandom};
      end else begin
        act_valid = 1'b0;
        wgt_valid = 1'b0;
      end
      @(negedge HCLK);
      if (res_valid) begin
        o_res_cycle = cyc;
        break;
      end
      fire = act_valid && act_ready && wgt_valid && wgt_ready;
      if ((act_valid && act_ready) != (wgt_valid && wgt_ready)) o_bad_hs++;
      if (!fire && dp_valid != 4'd0) o_bad_hs++;
      if (fire) o_masks.push_back(dp_valid);
      @(posedge HCLK); #1;
      if (fire) idx++;
      cyc++;
    end
    act_valid = 1'b0;
    wgt_valid = 1'b0;
    o_fires = idx;
    if (o_res_cycle < 0) begin
      @(posedge HCLK); #1;
      return;
    end
    snap = res_o;
    for (int h = 0; h < g_hold; h++) begin
      if (g_start_in_done) begin
        start = 1'b1;
        len_in = 16'($urandom_range(64));
        relu_in = 1'($urandom);
        for (int n = 0; n < 4; n++) bias_in[n] = $urandom;
      end
      @(posedge HCLK); #1;
      start = 1'b0;
      @(negedge HCLK);
      if (!res_valid || busy !== 1'b1) o_unstable++;
      for (int n = 0; n < 4; n++) if (res_o[n] !== snap[n]) o_unstable++;
    end
    res_ready = 1'b1;
    o_res = res_o;
    @(posedge HCLK); #1;
    res_ready = 1'b0;
    @(negedge HCLK);
    o_idle_after = !busy && !res_valid;
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    act_valid = 1'b1;
    wgt_valid = 1'b1;
    res_ready = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    n_checks++;
    if ({busy, act_ready, wgt_ready, res_valid} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl got %b want 0000", {busy, act_ready, wgt_ready, res_valid});
    end
    n_checks++;
    if ({dp_valid, dp_a, dp_w[0], dp_w[3], dp_sum[0], dp_sum[3]} !== '0) begin
      n_errors++;
      $display("FAIL reset_dp got valid=%b a=%h sum0=%h want 0", dp_valid, dp_a, dp_sum[0]);
    end
    n_checks++;
    if ({res_o[0], res_o[1], res_o[2], res_o[3]} !== 128'd0) begin
      n_errors++;
      $display("FAIL reset_res got %h %h %h %h want 0", res_o[0], res_o[1], res_o[2], res_o[3]);
    end
    act_valid = 1'b0;
    wgt_valid = 1'b0;
    res_ready = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic setup_single_word(input logic relu, input logic [31:0] b1);
    g_len = 4;
    g_act.delete();
    g_wgt.delete();
    g_act.push_back(32'h04030201);
    g_wgt.push_back({32'h02020202, 32'h00000000, 32'hFFFFFFFF, 32'h01010101});
    g_bias = '{32'd0, b1, 32'd0, 32'd0};
    g_relu = relu;
    g_drop = 0;
    g_hold = 0;
    g_start_in_done = 1'b0;
  endtask

  task automatic test_single_word();
    logic [31:0] want [4];
    want = '{32'd10, 32'hFFFFFFF6, 32'd0, 32'd20};
    setup_single_word(1'b0, 32'd0);
    run_job();
    n_checks++;
    if (o_res_cycle != 2) begin
      n_errors++;
      $display("FAIL single_latency got %0d want 2", o_res_cycle);
    end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (o_res[n] !== want[n]) begin
        n_errors++;
        $display("FAIL single_res%0d got %h want %h", n, o_res[n], want[n]);
      end
    end
  endtask

  task automatic test_relu_bias();
    logic [31:0] want [4];
    want = '{32'd10, 32'd0, 32'd0, 32'd20};
    setup_single_word(1'b1, 32'd5);
    run_job();
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (o_res[n] !== want[n]) begin
        n_errors++;
        $display("FAIL relu_res%0d got %h want %h", n, o_res[n], want[n]);
      end
    end
  endtask

  task automatic test_partial_tail();
    g_len = 6;
    g_act.delete();
    g_wgt.delete();
    g_act.push_back(32'h01010101);
    g_act.push_back(32'hFFFF0303);
    g_wgt.push_back({4{32'h01010101}});
    g_wgt.push_back({4{32'h01010101}});
    g_bias = '{default: 32'd0};
    g_relu = 1'b0;
    g_drop = 0;
    g_hold = 0;
    g_start_in_done = 1'b0;
    run_job();
    n_checks++;
    if (o_masks.size() != 2 || o_masks[0] !== 4'b1111 || o_masks[1] !== 4'b0011) begin
      n_errors++;
      $display("FAIL tail_masks got %p want 1111,0011", o_masks);
    end
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (o_res[n] !== 32'd10) begin
        n_errors++;
        $display("FAIL tail_res%0d got %h want %h", n, o_res[n], 32'd10);
      end
    end
  endtask

  task automatic test_backpressure();
    make_job(20);
    for (int n = 0; n < 4; n++) g_bias[n] = $urandom;
    g_relu = 1'b0;
    g_drop = 40;
    g_hold = 5;
    g_start_in_done = 1'b0;
    run_job();
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (o_res[n] !== model_res(n)) begin
        n_errors++;
        $display("FAIL stall_res%0d got %h want %h", n, o_res[n], model_res(n));
      end
    end
    n_checks++;
    if (o_unstable != 0 || o_bad_hs != 0 || o_fires != 5) begin
      n_errors++;
      $display("FAIL stall_protocol got unstable=%0d badhs=%0d fires=%0d want 0 0 5",
               o_unstable, o_bad_hs, o_fires);
    end
  endtask

  task automatic test_len0_ignored_start();
    make_job(0);
    g_bias[0] = 32'hFFFFFFFD;
    for (int n = 1; n < 4; n++) g_bias[n] = $urandom;
    g_relu = 1'b0;
    g_drop = 0;
    g_hold = 3;
    g_start_in_done = 1'b1;
    run_job();
    n_checks++;
    if (o_res_cycle != 1 || o_res[0] !== 32'hFFFFFFFD) begin
      n_errors++;
      $display("FAIL len0_res0 got cyc=%0d res=%h want cyc=1 res=fffffffd", o_res_cycle, o_res[0]);
    end
    for (int n = 1; n < 4; n++) begin
      n_checks++;
      if (o_res[n] !== g_bias[n]) begin
        n_errors++;
        $display("FAIL len0_res%0d got %h want %h", n, o_res[n], g_bias[n]);
      end
    end
    n_checks++;
    if (o_unstable != 0 || o_idle_after !== 1'b1) begin
      n_errors++;
      $display("FAIL len0_ignored_start got unstable=%0d idle=%b want 0 1", o_unstable, o_idle_after);
    end
  endtask

  task automatic test_reset_mid_run();
    len_in = 16'd32;
    for (int n = 0; n < 4; n++) bias_in[n] = $urandom;
    start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    act_valid = 1'b1;
    wgt_valid = 1'b1;
    repeat (2) begin
      act_data = $urandom;
      wgt_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge HCLK); #1;
    end
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    n_checks++;
    if ({busy, act_ready, wgt_ready, res_valid, dp_valid} !== 8'd0 || dp_a !== 32'd0) begin
      n_errors++;
      $display("FAIL midreset_ctrl got busy=%b ar=%b wr=%b rv=%b dpv=%b want 0",
               busy, act_ready, wgt_ready, res_valid, dp_valid);
    end
    n_checks++;
    if ({dp_sum[0], dp_sum[1], dp_sum[2], dp_sum[3], res_o[0], res_o[1], res_o[2], res_o[3],
         dp_w[0], dp_w[1], dp_w[2], dp_w[3]} !== '0) begin
      n_errors++;
      $display("FAIL midreset_data got sum0=%h res0=%h w0=%h want 0", dp_sum[0], res_o[0], dp_w[0]);
    end
    act_valid = 1'b0;
    wgt_valid = 1'b0;
    @(posedge HCLK); #1;
    make_job(13);
    for (int n = 0; n < 4; n++) g_bias[n] = $urandom;
    g_relu = 1'b0;
    g_drop = 0;
    g_hold = 0;
    g_start_in_done = 1'b0;
    run_job();
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (o_res[n] !== model_res(n)) begin
        n_errors++;
        $display("FAIL midreset_fresh%0d got %h want %h", n, o_res[n], model_res(n));
      end
    end
  endtask

  task automatic test_random();
    int unsigned words;
    for (int j = 0; j < 8; j++) begin
      make_job($urandom_range(37));
      for (int n = 0; n < 4; n++) g_bias[n] = $urandom;
      g_relu = 1'($urandom);
      g_drop = (j % 2 == 0) ? 0 : int'($urandom_range(50));
      g_hold = int'($urandom_range(3));
      g_start_in_done = 1'($urandom);
      words = (g_len + 3) / 4;
      run_job();
      for (int n = 0; n < 4; n++) begin
        n_checks++;
        if (o_res[n] !== model_res(n)) begin
          n_errors++;
          $display("FAIL rand%0d_res%0d got %h want %h", j, n, o_res[n], model_res(n));
        end
      end
      n_checks++;
      if (o_fires != int'(words) || o_bad_hs != 0 || o_unstable != 0 || o_idle_after !== 1'b1) begin
        n_errors++;
        $display("FAIL rand%0d_protocol got fires=%0d badhs=%0d unstable=%0d idle=%b want %0d 0 0 1",
                 j, o_fires, o_bad_hs, o_unstable, o_idle_after, words);
      end
      if (g_drop == 0) begin
        n_checks++;
        if (o_res_cycle != int'(words) + 1) begin
          n_errors++;
          $display("FAIL rand%0d_latency got %0d want %0d", j, o_res_cycle, words + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_relu_bias();
    test_partial_tail();
    test_backpressure();
    test_len0_ignored_start();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
